pipe_hazard_ctrl: RTL

- Central stall/flush/freeze sequencer for the 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Drives PC write enable, IFID hold/flush, IDEX bubble insertion and a global stage enable.
- Owns the request/ack handshake to a variable-latency Data_Memory, with a timeout that halts the core on a hung memory.

---
 rtl/pipe_ctrl_pkg.sv | 21 ++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state type and sizing helpers for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2,
        HALT     = 2'd3
    } state_e;

    localparam int unsigned REG_AW_DEF      = 5;
    localparam int unsigned MEM_TIMEOUT_DEF = 64;

    // Wide enough to hold the value MEM_TIMEOUT itself.
    function automatic int unsigned wait_cnt_w(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

    localparam int unsigned WAIT_CNT_W_DEF = wait_cnt_w(MEM_TIMEOUT_DEF);

endpackage

// File: rtl/mem_wait_timer.sv
// Memory-wait cycle counter: load to 1, increment, clear, and flag when the
// count equals LIMIT.
module mem_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned W     = WAIT_CNT_W_DEF,
    parameter int unsigned LIMIT = MEM_TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (load_i) begin
            r_cnt <= W'(1);
        end else if (inc_i) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign at_limit_o = (r_cnt == LIMIT_V);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline with Data_Memory wait
// timeout. Optional perf counters: define PIPE_HAZARD_CTRL_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned REG_AW      = REG_AW_DEF,
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_uses_rs2_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              branch_taken_i,
    input  logic              mem_cmd_i,
    input  logic              mem_ack_i,
    output logic              PCWrite_o,
    output logic              PCSrc_o,
    output logic              Stall_o,
    output logic              Flush_o,
    output logic              NoOp_o,
    output logic              stage_en_o,
    output logic              mem_req_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    localparam int unsigned WAIT_W = wait_cnt_w(MEM_TIMEOUT);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_err;
    logic   w_set_err;
    logic   w_load_use;
    logic   w_tmr_load;
    logic   w_tmr_inc;
    logic   w_tmr_clr;
    logic   w_tmr_at_limit;

    assign w_load_use = ex_memread_i && (ex_rd_i != '0) &&
                        ((ex_rd_i == id_rs1_i) ||
                         (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));

    mem_wait_timer #(
        .W     (WAIT_W),
        .LIMIT (MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (w_tmr_load),
        .inc_i      (w_tmr_inc),
        .clr_i      (w_tmr_clr),
        .at_limit_o (w_tmr_at_limit)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_set_err   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_inc   = 1'b0;
        w_tmr_clr   = 1'b0;
        PCWrite_o   = 1'b0;
        PCSrc_o     = 1'b0;
        Stall_o     = 1'b0;
        Flush_o     = 1'b0;
        NoOp_o      = 1'b0;
        stage_en_o  = 1'b0;
        mem_req_o   = 1'b0;

        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = RUN;
                end
            end
            RUN, MEM_WAIT: begin
                // An acked wait cycle resolves hazards exactly like a RUN cycle.
                mem_req_o = (r_state == MEM_WAIT) ? 1'b1 : mem_cmd_i;
                if ((r_state == RUN) ? (mem_cmd_i && !mem_ack_i) : !mem_ack_i) begin
                    Stall_o = 1'b1;
                    if (r_state == RUN) begin
                        w_state_nxt = MEM_WAIT;
                        w_tmr_load  = 1'b1;
                    end else if (w_tmr_at_limit) begin
                        w_set_err   = 1'b1;
                        w_state_nxt = HALT;
                    end else begin
                        w_tmr_inc = 1'b1;
                    end
                end else begin
                    stage_en_o = 1'b1;
                    PCWrite_o  = !w_load_use;
                    Stall_o    = w_load_use;
                    NoOp_o     = w_load_use;
                    Flush_o    = branch_taken_i && !w_load_use;
                    PCSrc_o    = branch_taken_i && !w_load_use;
                    if (r_state == MEM_WAIT) begin
                        w_state_nxt = RUN;
                        w_tmr_clr   = 1'b1;
                    end
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;

`ifdef PIPE_HAZARD_CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (Stall_o) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (Flush_o) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule
